instr_fetch: RTL

//  Instruction-fetch stage feeding the Decoder (op field) and the datapath.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/instr_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t RUN   = 2'd0;
    localparam fetch_state_t HOLD  = 2'd1;
    localparam fetch_state_t FLUSH = 2'd2;
    localparam int INSTR_W = 32;
    localparam int OP_W = 6;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction+pc register that catches the response
// which lands while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, 1-cycle-latency imem request/response tracking, stall skid
// and redirect flush; presents one fetched instruction per cycle to decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [OP_W-1:0]    op_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_plus4_o
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc, r_inf_pc, r_pc_out;
    logic               r_inf_v, r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic               w_hold, w_resp_v, w_skid_v;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc, w_target;

    assign w_hold      = stall_i & r_valid;
    // A response landing in FLUSH belongs to a wrong-path request
    assign w_resp_v    = r_inf_v & (r_state != FLUSH);
    assign w_target    = redirect_pc_i & ALIGN_MASK;
    assign imem_req_o  = rst_i & ~w_hold;
    assign imem_addr_o = r_pc;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (~redirect_i & w_hold & w_resp_v),
        .i_clear (redirect_i | ~w_hold),
        .i_instr (imem_instr_i),
        .i_pc    (r_inf_pc),
        .o_valid (w_skid_v),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_inf_v  <= 1'b0;
            r_inf_pc <= '0;
            r_valid  <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_pc_out <= '0;
        end else begin
            r_inf_v  <= imem_req_o;
            r_inf_pc <= r_pc;
            if (redirect_i) begin
                r_state <= FLUSH;
                r_pc    <= w_target;
                r_valid <= 1'b0;
            end else begin
                r_state <= w_hold ? HOLD : RUN;
                if (imem_req_o)
                    r_pc <= r_pc + STEP;
                if (!w_hold) begin
                    r_valid  <= w_skid_v | w_resp_v;
                    r_instr  <= w_skid_v ? w_skid_instr : w_resp_v ? imem_instr_i : r_instr;
                    r_pc_out <= w_skid_v ? w_skid_pc : w_resp_v ? r_inf_pc : r_pc_out;
                end
            end
        end
    end

    assign valid_o    = r_valid;
    assign instr_o    = r_instr;
    assign op_o       = r_instr[INSTR_W-1 -: OP_W];
    assign pc_o       = r_pc_out;
    assign pc_plus4_o = r_pc_out + STEP;
endmodule
